// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared port enum and reset constant for the RAM arbiter
package ram_arb_pkg;
   typedef enum logic {PORT_A = 1'b0, PORT_B = 1'b1} port_e;
   localparam port_e LAST_RESET = PORT_B;
endpackage

// File: rtl/ram_arbiter_rr_pick2.sv
// rr_pick2: combinational two-input picker with one-hot grant
// Ports: req_a/req_b requests, last = previous winner, gnt[0]=A gnt[1]=B.
// Build option: RAM_ARB_ROUND_ROBIN_EN selects round-robin ties, else A wins ties.
module rr_pick2
   import ram_arb_pkg::*;
(
   input  logic       req_a,
   input  logic       req_b,
   input  port_e      last,
   output logic [1:0] gnt
);
`ifdef RAM_ARB_ROUND_ROBIN_EN
   // On a tie A wins only if B took the previous transfer
   assign gnt[0] = req_a && (!req_b || last == PORT_B);
`else
   logic unused_last;
   assign unused_last = last;
   assign gnt[0] = req_a;
`endif
   assign gnt[1] = req_b && !gnt[0];
endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port sync RAM (1-cycle read) between ports A and B
// Ports: clk, rst (async, active-high); per port valid/ready/addr/wren/wdata
// request and rvalid/rdata response; ram_addr/ram_wren/ram_wdata to the RAM,
// ram_rdata from it. Build option: RAM_ARB_ROUND_ROBIN_EN (see rr_pick2).
module ram_arbiter
   import ram_arb_pkg::*;
#(
   parameter int ADDR_SIZE = 11,
   parameter int DATA_SIZE = 9
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 a_valid,
   output logic                 a_ready,
   input  logic [ADDR_SIZE-1:0] a_addr,
   input  logic                 a_wren,
   input  logic [DATA_SIZE-1:0] a_wdata,
   output logic                 a_rvalid,
   output logic [DATA_SIZE-1:0] a_rdata,
   input  logic                 b_valid,
   output logic                 b_ready,
   input  logic [ADDR_SIZE-1:0] b_addr,
   input  logic                 b_wren,
   input  logic [DATA_SIZE-1:0] b_wdata,
   output logic                 b_rvalid,
   output logic [DATA_SIZE-1:0] b_rdata,
   output logic [ADDR_SIZE-1:0] ram_addr,
   output logic                 ram_wren,
   output logic [DATA_SIZE-1:0] ram_wdata,
   input  logic [DATA_SIZE-1:0] ram_rdata
);
   port_e      last;
   logic [1:0] gnt;
   logic       pend_a, pend_b;
   rr_pick2 u_pick (
      .req_a(a_valid),
      .req_b(b_valid),
      .last (last),
      .gnt  (gnt)
   );
   assign a_ready   = gnt[0];
   assign b_ready   = gnt[1];
   // Idle cycles drive zeros so the RAM never sees a stray write
   assign ram_wren  = gnt[0] ? a_wren  : gnt[1] ? b_wren  : 1'b0;
   assign ram_addr  = gnt[0] ? a_addr  : gnt[1] ? b_addr  : '0;
   assign ram_wdata = gnt[0] ? a_wdata : gnt[1] ? b_wdata : '0;
   assign a_rvalid  = pend_a;
   assign b_rvalid  = pend_b;
   assign a_rdata   = ram_rdata;
   assign b_rdata   = ram_rdata;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         last   <= LAST_RESET;
         pend_a <= 1'b0;
         pend_b <= 1'b0;
      end else begin
         pend_a <= gnt[0] && !a_wren;
         pend_b <= gnt[1] && !b_wren;
         if (|gnt) last <= gnt[0] ? PORT_A : PORT_B;
      end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: self-checking bench for ram_arbiter with a behavioural RAM
module tb_ram_arbiter;
`ifdef RAM_ARB_ROUND_ROBIN_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif
   logic clk = 1'b0, rst = 1'b1;
   logic a_valid = 1'b0, a_wren = 1'b0, b_valid = 1'b0, b_wren = 1'b0;
   logic [10:0] a_addr = '0, b_addr = '0;
   logic [8:0] a_wdata = '0, b_wdata = '0;
   logic a_ready, b_ready, a_rvalid, b_rvalid, ram_wren;
   logic [8:0] a_rdata, b_rdata, ram_wdata, ram_rdata;
   logic [10:0] ram_addr;
   int checks = 0, errors = 0;

   ram_arbiter dut (
      .clk(clk), .rst(rst),
      .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_wren(a_wren),
      .a_wdata(a_wdata), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
      .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_wren(b_wren),
      .b_wdata(b_wdata), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
      .ram_addr(ram_addr), .ram_wren(ram_wren), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata)
   );

   always #5 clk = ~clk;

   // Behavioural read-before-write RAM with registered output
   logic [8:0] mem [0:2047];
   always @(posedge clk) begin
      ram_rdata <= mem[ram_addr];
      if (ram_wren) mem[ram_addr] <= ram_wdata;
   end

   // Reference model state: previous winner (1 = B), pending responses, memory image
   bit m_last = 1'b1, m_pa = 1'b0, m_pb = 1'b0, m_rd_known = 1'b0;
   logic [8:0] m_rd = '0;
   logic [8:0] m_mem [0:2047];
   bit m_known [0:2047];
   bit g_a, g_b;
   logic o_ar, o_br, o_arv, o_brv;
   logic [8:0] o_rd;

   function automatic void chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endfunction

   // One clock cycle: called at posedge+1, returns at next posedge+1
   task automatic cycle(input logic av, aw, input logic [10:0] aa, input logic [8:0] ad,
                        input logic bv, bw, input logic [10:0] ba, input logic [8:0] bd);
      logic [10:0] wa;
      a_valid = av; a_wren = aw; a_addr = aa; a_wdata = ad;
      b_valid = bv; b_wren = bw; b_addr = ba; b_wdata = bd;
      g_a = (av && bv) ? (RR ? m_last : 1'b1) : av;
      g_b = bv && !g_a;
      #4;
      o_ar = a_ready; o_br = b_ready; o_arv = a_rvalid; o_brv = b_rvalid; o_rd = a_rdata;
      chk("a_ready", int'(a_ready), int'(g_a));
      chk("b_ready", int'(b_ready), int'(g_b));
      chk("ram_wren", int'(ram_wren), g_a ? int'(aw) : g_b ? int'(bw) : 0);
      chk("ram_addr", int'(ram_addr), g_a ? int'(aa) : g_b ? int'(ba) : 0);
      chk("ram_wdata", int'(ram_wdata), g_a ? int'(ad) : g_b ? int'(bd) : 0);
      chk("a_rvalid", int'(a_rvalid), int'(m_pa));
      chk("b_rvalid", int'(b_rvalid), int'(m_pb));
      if ((m_pa || m_pb) && m_rd_known) begin
         chk("a_rdata", int'(a_rdata), int'(m_rd));
         chk("b_rdata", int'(b_rdata), int'(m_rd));
      end
      m_pa = g_a && !aw;
      m_pb = g_b && !bw;
      if (g_a || g_b) begin
         wa = g_a ? aa : ba;
         m_rd = m_mem[wa];
         m_rd_known = m_known[wa];
         if (g_a ? aw : bw) begin
            m_mem[wa] = g_a ? ad : bd;
            m_known[wa] = 1'b1;
         end
         m_last = g_b;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
   endtask

   typedef struct {
      logic av, aw; logic [10:0] aa; logic [8:0] ad;
      logic bv, bw; logic [10:0] ba; logic [8:0] bd;
      logic ear, ebr, earv, ebrv; int erd;
   } vec_t;
   vec_t tbl [9];

   logic hav, haw, hbv, hbw;
   logic [10:0] haa, hba;
   logic [8:0] had, hbd;

   initial begin
      tbl[0] = '{1'b1, 1'b1, 11'h010, 9'h1A5, 1'b0, 1'b0, 11'h000, 9'h000, 1'b1, 1'b0, 1'b0, 1'b0, -1};
      tbl[1] = '{1'b1, 1'b0, 11'h010, 9'h000, 1'b0, 1'b0, 11'h000, 9'h000, 1'b1, 1'b0, 1'b0, 1'b0, -1};
      tbl[2] = '{1'b0, 1'b0, 11'h000, 9'h000, 1'b1, 1'b1, 11'h020, 9'h0B2, 1'b0, 1'b1, 1'b1, 1'b0, 'h1A5};
      tbl[3] = '{1'b1, 1'b0, 11'h010, 9'h000, 1'b1, 1'b0, 11'h020, 9'h000, 1'b1, 1'b0, 1'b0, 1'b0, -1};
      tbl[4] = '{1'b1, 1'b0, 11'h010, 9'h000, 1'b1, 1'b0, 11'h020, 9'h000, !RR, RR, 1'b1, 1'b0, 'h1A5};
      tbl[5] = '{1'b1, 1'b0, 11'h010, 9'h000, 1'b1, 1'b0, 11'h020, 9'h000, 1'b1, 1'b0, !RR, RR, RR ? 'h0B2 : 'h1A5};
      tbl[6] = '{1'b1, 1'b0, 11'h010, 9'h000, 1'b1, 1'b0, 11'h020, 9'h000, !RR, RR, 1'b1, 1'b0, 'h1A5};
      tbl[7] = '{1'b0, 1'b0, 11'h000, 9'h000, 1'b1, 1'b0, 11'h020, 9'h000, 1'b0, 1'b1, !RR, RR, RR ? 'h0B2 : 'h1A5};
      tbl[8] = '{1'b0, 1'b0, 11'h000, 9'h000, 1'b0, 1'b0, 11'h000, 9'h000, 1'b0, 1'b0, 1'b0, 1'b1, 'h0B2};
      for (int i = 0; i < 2048; i++) m_known[i] = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset a_rvalid", int'(a_rvalid), 0);
      chk("reset b_rvalid", int'(b_rvalid), 0);
      rst = 1'b0;
      for (int i = 0; i < 9; i++) begin
         cycle(tbl[i].av, tbl[i].aw, tbl[i].aa, tbl[i].ad, tbl[i].bv, tbl[i].bw, tbl[i].ba, tbl[i].bd);
         chk($sformatf("vec%0d a_ready", i), int'(o_ar), int'(tbl[i].ear));
         chk($sformatf("vec%0d b_ready", i), int'(o_br), int'(tbl[i].ebr));
         chk($sformatf("vec%0d a_rvalid", i), int'(o_arv), int'(tbl[i].earv));
         chk($sformatf("vec%0d b_rvalid", i), int'(o_brv), int'(tbl[i].ebrv));
         if (tbl[i].erd >= 0) chk($sformatf("vec%0d rdata", i), int'(o_rd), tbl[i].erd);
      end
      // Reset dropped on an in-flight B read
      cycle(1'b1, 1'b1, 11'h3FF, 9'h15C, 1'b0, 1'b0, '0, '0);
      cycle(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 11'h3FF, '0);
      a_valid = 1'b0; b_valid = 1'b0;
      chk("inflight b_rvalid", int'(b_rvalid), 1);
      rst = 1'b1;
      #1;
      chk("async clear b_rvalid", int'(b_rvalid), 0);
      m_pa = 1'b0; m_pb = 1'b0; m_last = 1'b1;
      #2 rst = 1'b0;
      @(posedge clk);
      #1;
      idle();
      chk("post reset b_rvalid", int'(o_brv), 0);
      cycle(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 11'h3FF, '0);
      idle();
      chk("reread b_rvalid", int'(o_brv), 1);
      chk("reread rdata", int'(o_rd), 'h15C);
      // A write then B read of the same word, every cycle
      for (int i = 0; i < 8; i++) begin
         cycle(1'b1, 1'b1, 11'h055, 9'(i * 37 + 5), 1'b0, 1'b0, '0, '0);
         cycle(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 11'h055, '0);
      end
      idle();
      chk("last alt rdata", int'(o_rd), 7 * 37 + 5);
      // Random traffic obeying hold-until-accepted
      hav = 1'b0; hbv = 1'b0; haw = 1'b0; hbw = 1'b0;
      haa = '0; hba = '0; had = '0; hbd = '0;
      for (int i = 0; i < 400; i++) begin
         if (!(hav && !g_a)) begin
            hav = ($urandom_range(9) < 7); haw = 1'(($urandom_range(1)));
            haa = 11'($urandom_range(15)); had = 9'($urandom);
         end
         if (!(hbv && !g_b)) begin
            hbv = ($urandom_range(9) < 7); hbw = 1'(($urandom_range(1)));
            hba = 11'($urandom_range(15)); hbd = 9'($urandom);
         end
         cycle(hav, haw, haa, had, hbv, hbw, hba, hbd);
      end
      idle();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
